// File: rtl/llc_input_arbiter_n.sv
// LLC input arbiter: N-channel fixed-priority-with-aging or round-robin grant
// into a decision FIFO whose head feeds the lookup stage and stall release.
module llc_input_arbiter_n #(
   parameter int unsigned N_CH         = 4,
   parameter int unsigned LINE_W       = 28,
   parameter int unsigned SET_W        = 10,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned RR_MODE      = 0,
   parameter int unsigned STARVE_LIMIT = 15,
   parameter int unsigned RSP_CH       = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_CH-1:0]                ch_valid,
   input  logic [N_CH-1:0]                ch_stall,
   input  logic [N_CH*LINE_W-1:0]         ch_addr,
   output logic [N_CH-1:0]                ch_ready,
   input  logic                           flush,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [$clog2(N_CH)-1:0]        out_ch,
   output logic [SET_W-1:0]               out_set,
   output logic [LINE_W-SET_W-1:0]        out_tag,
   input  logic                           stall_active,
   input  logic [SET_W-1:0]               stall_set,
   input  logic [LINE_W-SET_W-1:0]        stall_tag,
   output logic                           clr_stall,
   output logic [$clog2(FIFO_DEPTH):0]    usage,
   output logic                           fifo_full,
   output logic                           idle
);
   localparam int unsigned CH_W  = $clog2(N_CH);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned USE_W = PTR_W + 1;

   logic [N_CH-1:0]   elig;
   logic [N_CH-1:0]   starved;
   logic [7:0]        age [N_CH];
   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   gnt_idx;
   logic              gnt_found;
   logic              push;
   logic              pop;
   logic [LINE_W-1:0] gnt_addr;
   logic [LINE_W-1:0] head_addr;
   logic [CH_W-1:0]   fifo_ch [FIFO_DEPTH];
   logic [LINE_W-1:0] fifo_addr [FIFO_DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [USE_W-1:0]  usage_next;

   function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] ptr, input int unsigned k);
      return CH_W'((32'(ptr) + k) % N_CH);
   endfunction

   always_comb begin
      elig    = ch_valid & ~ch_stall;
      starved = '0;
      for (int unsigned i = 0; i < N_CH; i++)
         starved[i] = elig[i] && (age[i] == 8'(STARVE_LIMIT));
   end

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      if (RR_MODE != 0) begin
         for (int unsigned k = 1; k <= N_CH; k++) begin
            if (!gnt_found && elig[rr_idx(rr_ptr, k)]) begin
               gnt_found = 1'b1;
               gnt_idx   = rr_idx(rr_ptr, k);
            end
         end
      end else begin
         // starved channels outrank plain priority order
         for (int unsigned i = 0; i < N_CH; i++) begin
            if (!gnt_found && starved[i]) begin
               gnt_found = 1'b1;
               gnt_idx   = CH_W'(i);
            end
         end
         for (int unsigned i = 0; i < N_CH; i++) begin
            if (!gnt_found && elig[i]) begin
               gnt_found = 1'b1;
               gnt_idx   = CH_W'(i);
            end
         end
      end
   end

   assign push      = gnt_found && !fifo_full && !flush;
   assign pop       = out_valid && out_ready && !flush;
   assign gnt_addr  = ch_addr[gnt_idx*LINE_W +: LINE_W];
   assign head_addr = fifo_addr[head];
   assign out_ch    = fifo_ch[head];
   assign out_set   = head_addr[SET_W-1:0];
   assign out_tag   = head_addr[LINE_W-1:SET_W];
   assign out_valid = (usage != '0);
   assign fifo_full = (usage == USE_W'(FIFO_DEPTH));
   assign clr_stall = pop && stall_active && (out_ch == CH_W'(RSP_CH)) &&
                      (out_set == stall_set) && (out_tag == stall_tag);

   always_comb begin
      ch_ready = '0;
      if (push && rst)
         ch_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      if (flush)
         usage_next = '0;
      else
         usage_next = usage + USE_W'(push) - USE_W'(pop);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < N_CH; i++)
            age[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            if (flush || (RR_MODE != 0) || !elig[i] || (push && gnt_idx == CH_W'(i)))
               age[i] <= '0;
            else if (age[i] != 8'(STARVE_LIMIT))
               age[i] <= age[i] + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rr_ptr <= CH_W'(N_CH - 1);
      else if (flush)
         rr_ptr <= CH_W'(N_CH - 1);
      else if (push)
         rr_ptr <= gnt_idx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         usage <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            fifo_ch[i]   <= '0;
            fifo_addr[i] <= '0;
         end
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         usage <= '0;
      end else begin
         if (push) begin
            fifo_ch[tail]   <= gnt_idx;
            fifo_addr[tail] <= gnt_addr;
            tail            <= tail + 1'b1;
         end
         if (pop)
            head <= head + 1'b1;
         usage <= usage_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         idle <= 1'b1;
      else
         idle <= ~|elig && (usage_next == '0);
   end
endmodule
